// File: rtl/tinyriscv_pkg.sv
// Shared core definitions: instruction funct3 codes, bus widths
// and the state encoding of the multi-cycle divider.
package tinyriscv_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CALC  = 2'd2,
        END   = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; outputs are valid while in END.
module div_seq
    import tinyriscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [4:0]       reg_waddr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       reg_waddr_o
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic [4:0]       rd_r;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;

    logic             sgn;
    logic             is_rem;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // One restore step; quotient bits shift into the low end of dvd.
    always_comb begin
        sgn     = (op_r == INST_DIV) || (op_r == INST_REM);
        is_rem  = (op_r == INST_REM) || (op_r == INST_REMU);
        shifted = {rem, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        ge      = ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt = {dvd[WIDTH-2:0], ge};
        quo_fix = neg_q ? -quo_nxt : quo_nxt;
        rem_fix = neg_r ? -rem_nxt : rem_nxt;
    end

    // Sequencer: latch, load magnitudes, iterate, publish result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_r        <= '0;
            dividend_r  <= '0;
            divisor_r   <= '0;
            rd_r        <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
            result_o    <= '0;
            reg_waddr_o <= '0;
        end else if (flush_i && state != IDLE) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
            result_o    <= '0;
            reg_waddr_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        op_r       <= op_i;
                        dividend_r <= dividend_i;
                        divisor_r  <= divisor_i;
                        rd_r       <= reg_waddr_i;
                        busy_o     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (divisor_r == '0) begin
                        result_o    <= is_rem ? dividend_r : '1;
                        ready_o     <= 1'b1;
                        reg_waddr_o <= rd_r;
                        state       <= END;
                    end else begin
                        dvd   <= (sgn && dividend_r[WIDTH-1])
                                 ? -dividend_r : dividend_r;
                        dvs   <= (sgn && divisor_r[WIDTH-1])
                                 ? -divisor_r : divisor_r;
                        neg_q <= sgn &&
                                 (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
                        neg_r <= sgn && dividend_r[WIDTH-1];
                        rem   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    dvd <= quo_nxt;
                    if (cnt == '0) begin
                        result_o    <= is_rem ? rem_fix : quo_fix;
                        ready_o     <= 1'b1;
                        reg_waddr_o <= rd_r;
                        state       <= END;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                END: begin
                    busy_o      <= 1'b0;
                    ready_o     <= 1'b0;
                    result_o    <= '0;
                    reg_waddr_o <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
